// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: credit-based IMEM issue feeding a (pc, inst) FIFO
// Ports:
//   clk, reset                clock; asynchronous active-high reset
//   imem_en, imem_addr        one read request per cycle to the synchronous-read IMEM
//   imem_rdata                IMEM data, valid the cycle after imem_en
//   redirect_valid, redirect_pc  flush queue and in-flight read, restart fetch at target
//   out_valid, out_ready      head-of-queue handshake toward decode
//   out_pc, out_inst          head entry
//   fifo_count                current queue occupancy
module fetch_unit #(
  parameter int               XLEN        = 64,
  parameter int               DEPTH       = 4,
  parameter int               IMEM_ADDR_W = 8,
  parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_v;
  logic            inflight_kill;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     credit_need;
  logic            unused_redirect_lsbs;

  assign pop  = out_valid & out_ready;
  // A read returning during a redirect cycle is dropped here; the redirect
  // itself clears the queue at the end of that cycle.
  assign push = inflight_v & ~inflight_kill & ~redirect_valid;

  // Occupancy the queue will have once the outstanding read lands, counting
  // this cycle's pop; issue only if that still leaves room for one more.
  assign credit_need = {1'b0, count} + {{CW{1'b0}}, inflight_v} - {{CW{1'b0}}, pop};
  assign issue       = ~reset & ~redirect_valid & (credit_need < (CW+1)'(DEPTH));

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_ADDR_W+1:2];

  assign out_valid  = (count != '0);
  assign out_pc     = mem_pc[rd_ptr];
  assign out_inst   = mem_inst[rd_ptr];
  assign fifo_count = count;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Fetch PC and the single outstanding IMEM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc      <= RESET_PC;
      inflight_pc   <= '0;
      inflight_v    <= 1'b0;
      inflight_kill <= 1'b0;
    end else begin
      inflight_v    <= issue;
      // Held low: a redirect discards the returning read through push gating,
      // so no per-read kill marker is ever needed.
      inflight_kill <= 1'b0;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end else if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end
    end
  end

  // Circular (pc, inst) queue; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= inflight_pc;
        mem_inst[wr_ptr] <= imem_rdata;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_en;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [$clog2(DEPTH):0] fifo_count;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .IMEM_ADDR_W(AW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // IMEM model: word k holds 0x1000 + k, one-cycle read latency.
  logic [31:0] imem [256];
  initial for (int i = 0; i < 256; i++) imem[i] = 32'h1000 + i;
  always @(posedge clk) if (imem_en) imem_rdata <= imem[imem_addr];

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t x;
    x.pc   = pc;
    x.inst = 32'h1000 + {24'b0, pc[9:2]};
    sb.push_back(x);
  endtask

  task automatic push_lin(input logic [63:0] base, input int n);
    for (int k = 0; k < n; k++) push_exp(base + 64'(4 * k));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of cycle 0 with reset just released.
  task automatic start_stream(input logic ready);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = ready;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic end_test(input string name);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Stream from reset, redirect at cycle r (nr consecutive cycles), then
  // watch tail pops from the last target.
  task automatic redirect_run(input int r, input int nr, input logic [63:0] ta,
                              input logic [63:0] tb, input logic [63:0] exp_addr,
                              input int tail, input string name);
    start_stream(1'b1);
    for (int c = 0; c < r; c++) @(negedge clk);
    for (int i = 0; i < nr; i++) begin
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = (i == nr - 1) ? tb : ta;
      @(negedge clk);
      check("redir_no_issue", 64'(imem_en), 64'd0);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_count0", 64'(fifo_count), 64'd0);
    check("redir_valid_r1", 64'(out_valid), 64'd0);
    check("redir_issue_en", 64'(imem_en), 64'd1);
    check("redir_issue_addr", 64'(imem_addr), exp_addr);
    @(negedge clk);
    check("redir_valid_r2", 64'(out_valid), 64'd0);
    for (int i = 0; i < tail; i++) @(negedge clk);
    end_test(name);
  endtask

  // Monitor: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc %h want none", out_pc);
      end else begin
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_inst", 64'(out_inst), 64'(e.inst));
      end
    end
  end

  initial begin
    int ens;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_imem_en", 64'(imem_en), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);

    // Release with out_ready high: first read at addr 0, valid two cycles later, no gaps
    push_lin(64'h0, 10);
    start_stream(1'b1);
    @(negedge clk);
    check("t1_first_en", 64'(imem_en), 64'd1);
    check("t1_first_addr", 64'(imem_addr), 64'd0);
    @(negedge clk);
    check("t1_valid_c1", 64'(out_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_no_gap", 64'(out_valid), 64'd1);
    end
    end_test("t1_sb_empty");

    // Backpressure: exactly DEPTH reads, then drain in order and resume
    push_lin(64'h0, 10);
    start_stream(1'b0);
    ens = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_en) ens++;
    end
    check("t2_reads", 64'(ens), 64'd4);
    check("t2_count_sat", 64'(fifo_count), 64'd4);
    check("t2_en_low", 64'(imem_en), 64'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t2_no_gap", 64'(out_valid), 64'd1);
    end
    end_test("t2_sb_empty");

    // Redirect to 0x203 while pc 0x40 is in flight
    push_lin(64'h0, 16);
    push_lin(64'h200, 4);
    redirect_run(17, 1, 64'h0, 64'h203, 64'h80, 4, "t3_sb_empty");

    // Redirect in the same cycle as the pop of pc 0x10
    push_lin(64'h0, 5);
    push_lin(64'h100, 3);
    redirect_run(6, 1, 64'h0, 64'h100, 64'h40, 3, "t4_sb_empty");

    // Back-to-back redirects: last target wins
    push_lin(64'h0, 5);
    push_lin(64'h300, 3);
    redirect_run(6, 2, 64'h100, 64'h300, 64'hC0, 3, "t5_sb_empty");

    // Asynchronous reset with three queued entries
    start_stream(1'b0);
    for (int c = 0; c < 5; c++) @(negedge clk);
    check("t6_count3", 64'(fifo_count), 64'd3);
    #1 reset = 1'b1;
    #1;
    check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_count", 64'(fifo_count), 64'd0);
    check("t6_async_en", 64'(imem_en), 64'd0);
    push_lin(64'h0, 6);
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_restart_en", 64'(imem_en), 64'd1);
    check("t6_restart_addr", 64'(imem_addr), 64'd0);
    for (int c = 1; c < 8; c++) @(negedge clk);
    end_test("t6_sb_empty");

    // Random out_ready across pointer wrap
    push_lin(64'h0, 3 * DEPTH);
    start_stream(1'b0);
    for (int c = 0; c < 300; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      check("t7_count_le_depth", 64'(fifo_count <= DEPTH), 64'd1);
      if (sb.size() == 0) break;
      tick();
    end
    end_test("t7_sb_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
